// File: rtl/riscv_mc_sequencer_if.sv
// Control bundle between the multi-cycle sequencer and the rest of the RV32I core.
// The master side is the sequencer; the slave side is the datapath and memories.
interface riscv_mc_sequencer_if #(
  parameter int unsigned CNT_WIDTH = 32
);
  // Datapath and memory status into the sequencer
  logic [6:0]           opcode;
  logic [2:0]           funct3;
  logic [1:0]           addr_lo;
  logic                 br_taken;
  logic                 i_mem_rdy;
  logic                 d_mem_rdy;
  logic                 halt_req;

  // Control strobes, selects and status out of the sequencer
  logic [2:0]           state;
  logic                 i_mem_req;
  logic                 ir_we;
  logic                 pc_we;
  logic [1:0]           pc_src;
  logic                 d_mem_req;
  logic                 d_mem_we;
  logic [3:0]           d_mem_be;
  logic                 rf_we;
  logic [1:0]           wb_sel;
  logic [CNT_WIDTH-1:0] num_inst;
  logic                 halted;
  logic                 illegal;
  logic                 timeout;
  logic                 misalign;

  modport master (
    input  opcode, funct3, addr_lo, br_taken, i_mem_rdy, d_mem_rdy, halt_req,
    output state, i_mem_req, ir_we, pc_we, pc_src, d_mem_req, d_mem_we, d_mem_be,
           rf_we, wb_sel, num_inst, halted, illegal, timeout, misalign
  );

  modport slave (
    output opcode, funct3, addr_lo, br_taken, i_mem_rdy, d_mem_rdy, halt_req,
    input  state, i_mem_req, ir_we, pc_we, pc_src, d_mem_req, d_mem_we, d_mem_be,
           rf_we, wb_sel, num_inst, halted, illegal, timeout, misalign
  );
endinterface

// File: rtl/riscv_mc_sequencer.sv
// FETCH/DECODE/EXEC/MEM/WB control sequencer for the RV32I multi-cycle core, with
// ready-handshake stalls, access timeout, byte-enable generation and retire counting.
module riscv_mc_sequencer #(
  parameter int unsigned CNT_WIDTH   = 32,
  parameter int unsigned MEM_TIMEOUT = 0,
  parameter int unsigned WAIT_W      = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  riscv_mc_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5,
    S_TRAP   = 3'd6
  } state_t;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  localparam logic [WAIT_W:0] TMO_CNT = (WAIT_W + 1)'(MEM_TIMEOUT);

  state_t               state_reg, state_next;
  logic [WAIT_W-1:0]    wait_reg, wait_next;
  logic [CNT_WIDTH-1:0] count_reg, count_next;
  logic                 halted_reg, halted_next;
  logic                 illegal_reg, illegal_next;
  logic                 timeout_reg, timeout_next;
  logic                 misalign_reg, misalign_next;

  logic       is_load, is_store, is_branch, is_jal, is_jalr, is_legal;
  logic [3:0] be_c;
  logic       mis_c;
  logic [WAIT_W:0] wait_inc;
  logic       timeout_hit;

  logic       i_mem_req_c, ir_we_c, pc_we_c, d_mem_req_c, d_mem_we_c, rf_we_c;
  logic [3:0] d_mem_be_c;
  logic [1:0] pc_src_c, wb_sel_c;

  // funct3[2] only selects sign/zero extension, which the datapath handles
  logic unused_funct3_msb;
  assign unused_funct3_msb = bus.funct3[2];

  assign is_load   = (bus.opcode == OP_LOAD);
  assign is_store  = (bus.opcode == OP_STORE);
  assign is_branch = (bus.opcode == OP_BRANCH);
  assign is_jal    = (bus.opcode == OP_JAL);
  assign is_jalr   = (bus.opcode == OP_JALR);
  assign is_legal  = is_load | is_store | is_branch | is_jal | is_jalr |
                     (bus.opcode == OP_LUI) | (bus.opcode == OP_AUIPC) |
                     (bus.opcode == OP_IMM) | (bus.opcode == OP_OP);

  // Access size comes from funct3[1:0]; anything wider than half is treated as a word
  always_comb begin
    be_c  = 4'b1111;
    mis_c = (bus.addr_lo != 2'b00);
    case (bus.funct3[1:0])
      2'b00: begin
        be_c  = 4'b0001 << bus.addr_lo;
        mis_c = 1'b0;
      end
      2'b01: begin
        be_c  = 4'b0011 << {bus.addr_lo[1], 1'b0};
        mis_c = bus.addr_lo[0];
      end
      default: ;
    endcase
  end

  // The current not-ready cycle is counted, so a stall traps on exactly the Nth low cycle
  assign wait_inc    = {1'b0, wait_reg} + 1'b1;
  assign timeout_hit = (MEM_TIMEOUT != 0) && (wait_inc == TMO_CNT);

  always_comb begin
    state_next    = state_reg;
    wait_next     = wait_reg;
    halted_next   = halted_reg;
    illegal_next  = illegal_reg;
    timeout_next  = timeout_reg;
    misalign_next = misalign_reg;
    i_mem_req_c   = 1'b0;
    ir_we_c       = 1'b0;
    pc_we_c       = 1'b0;
    pc_src_c      = 2'd0;
    d_mem_req_c   = 1'b0;
    d_mem_we_c    = 1'b0;
    d_mem_be_c    = 4'b0000;
    rf_we_c       = 1'b0;
    wb_sel_c      = 2'd0;

    case (state_reg)
      S_FETCH: begin
        i_mem_req_c = 1'b1;
        if (bus.i_mem_rdy) begin
          ir_we_c    = 1'b1;
          state_next = S_DECODE;
          wait_next  = '0;
        end else if (timeout_hit) begin
          state_next   = S_TRAP;
          timeout_next = 1'b1;
          wait_next    = '0;
        end else begin
          wait_next = wait_inc[WAIT_W-1:0];
        end
      end
      S_DECODE: begin
        if (is_legal) begin
          state_next = S_EXEC;
        end else begin
          state_next   = S_TRAP;
          illegal_next = 1'b1;
        end
      end
      S_EXEC: begin
        wait_next = '0;
        if (is_load || is_store) begin
          state_next = S_MEM;
        end else if (is_branch) begin
          pc_we_c    = 1'b1;
          pc_src_c   = bus.br_taken ? 2'd1 : 2'd0;
          state_next = S_FETCH;
        end else begin
          state_next = S_WB;
        end
      end
      S_MEM: begin
        if (mis_c) begin
          state_next    = S_TRAP;
          misalign_next = 1'b1;
        end else begin
          d_mem_req_c = 1'b1;
          d_mem_we_c  = is_store;
          d_mem_be_c  = be_c;
          if (bus.d_mem_rdy) begin
            wait_next = '0;
            if (is_store) begin
              pc_we_c    = 1'b1;
              state_next = S_FETCH;
            end else begin
              state_next = S_WB;
            end
          end else if (timeout_hit) begin
            state_next   = S_TRAP;
            timeout_next = 1'b1;
            wait_next    = '0;
          end else begin
            wait_next = wait_inc[WAIT_W-1:0];
          end
        end
      end
      S_WB: begin
        rf_we_c    = 1'b1;
        pc_we_c    = 1'b1;
        wb_sel_c   = is_load ? 2'd1 : ((is_jal || is_jalr) ? 2'd2 : 2'd0);
        pc_src_c   = is_jal ? 2'd2 : (is_jalr ? 2'd3 : 2'd0);
        state_next = S_FETCH;
        wait_next  = '0;
      end
      S_HALT, S_TRAP: ;
      default: state_next = S_FETCH;
    endcase

    // A halting instruction still retires; only the follow-on fetch is suppressed
    if (pc_we_c && bus.halt_req) begin
      state_next  = S_HALT;
      halted_next = 1'b1;
    end
  end

  assign count_next = count_reg + CNT_WIDTH'(pc_we_c);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= S_FETCH;
      wait_reg     <= '0;
      count_reg    <= '0;
      halted_reg   <= 1'b0;
      illegal_reg  <= 1'b0;
      timeout_reg  <= 1'b0;
      misalign_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      wait_reg     <= wait_next;
      count_reg    <= count_next;
      halted_reg   <= halted_next;
      illegal_reg  <= illegal_next;
      timeout_reg  <= timeout_next;
      misalign_reg <= misalign_next;
    end
  end

  // Strobes are qualified by rst_n so nothing fires while reset is held
  assign bus.state     = state_reg;
  assign bus.i_mem_req = i_mem_req_c & rst_n;
  assign bus.ir_we     = ir_we_c & rst_n;
  assign bus.pc_we     = pc_we_c & rst_n;
  assign bus.pc_src    = pc_src_c;
  assign bus.d_mem_req = d_mem_req_c & rst_n;
  assign bus.d_mem_we  = d_mem_we_c & rst_n;
  assign bus.d_mem_be  = d_mem_be_c & {4{rst_n}};
  assign bus.rf_we     = rf_we_c & rst_n;
  assign bus.wb_sel    = wb_sel_c;
  assign bus.num_inst  = count_reg;
  assign bus.halted    = halted_reg;
  assign bus.illegal   = illegal_reg;
  assign bus.timeout   = timeout_reg;
  assign bus.misalign  = misalign_reg;

endmodule

// File: doc/riscv_mc_sequencer.md
# riscv_mc_sequencer

Parametrised multi-cycle control sequencer for the RV32I multi-cycle core. It replaces the single-step control decode with an explicit FETCH/DECODE/EXEC/MEM/WB state machine. The sequencer tolerates variable-latency instruction and data memories through ready handshakes, times out stalled accesses, generates byte enables with misalignment checking, and owns the retired-instruction counter and halt/trap status. It sits between the instruction register, ALU, memories and register file of the core top.

## Interface
- CNT_WIDTH, 32, width of retired-instruction counter NUM_INST
- MEM_TIMEOUT, 0, max consecutive not-ready cycles per memory access; 0 disables timeout
- WAIT_W, 8, width of wait counter; MEM_TIMEOUT < 2^WAIT_W

- CLK  in  1  clock, rising edge
- RSTn  in  1  reset, asynchronous, active-low
- OPCODE  in  7  IR[6:0]
- FUNCT3  in  3  IR[14:12]
- ADDR_LO  in  2  ALU_Result[1:0], the data access byte offset
- BR_TAKEN  in  1  branch compare result from ALU
- I_MEM_RDY  in  1  instruction word valid this cycle
- D_MEM_RDY  in  1  data access complete this cycle
- HALT_REQ  in  1  halt pattern detected by datapath
- STATE  out  3  current state encoding
- I_MEM_REQ, IR_WE, PC_WE  out  1 each  fetch request, IR load, PC load
- PC_SRC  out  2  0 = PC+4, 1 = branch target, 2 = JAL target, 3 = JALR target & ~1
- D_MEM_REQ, D_MEM_WE  out  1 each  data request, write strobe
- D_MEM_BE  out  4  byte enables
- RF_WE  out  1  register write
- WB_SEL  out  2  0 = ALU, 1 = load data, 2 = PC+4
- NUM_INST  out  CNT_WIDTH  retired instructions
- HALTED, ILLEGAL, TIMEOUT, MISALIGN  out  1 each  sticky status

## Operation
- States: FETCH = 0, DECODE = 1, EXEC = 2, MEM = 3, WB = 4, HALT = 5, TRAP = 6. HALT and TRAP are absorbing until reset.
- FETCH: I_MEM_REQ = 1. While I_MEM_RDY is low, the state holds. When I_MEM_RDY is high, IR_WE = 1 and the next state is DECODE.
- DECODE: a legal opcode goes to EXEC. The legal opcodes are LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM and OP. Any other opcode goes to TRAP and sets ILLEGAL.
- EXEC next state by instruction class:
  - LOAD/STORE go to MEM.
  - BRANCH goes to FETCH with PC_WE = 1 and PC_SRC = BR_TAKEN ? 1 : 0.
  - All other classes go to WB.
- MEM:
  - D_MEM_REQ = 1. D_MEM_WE = 1 for STORE.
  - D_MEM_BE from FUNCT3[1:0] and ADDR_LO:
    - byte: 0001 << ADDR_LO
    - half: 0011 << {ADDR_LO[1], 1'b0}
    - word: 1111
  - Misaligned access: half with ADDR_LO[0] = 1, or word with ADDR_LO ≠ 0. The next state is TRAP and MISALIGN is set. No request is issued: D_MEM_REQ, D_MEM_WE and D_MEM_BE are 0 that cycle.
  - The state holds until D_MEM_RDY. Then LOAD goes to WB; STORE goes to FETCH with PC_WE = 1 and PC_SRC = 0.
- WB:
  - RF_WE = 1, PC_WE = 1, next state FETCH.
  - WB_SEL: load = 1, JAL/JALR = 2, otherwise 0.
  - PC_SRC: JAL = 2, JALR = 3, otherwise 0.
- Retire: NUM_INST increments by 1 in every cycle with PC_WE = 1, wrapping modulo 2^CNT_WIDTH.
- Halt: if HALT_REQ = 1 in a retire cycle, the instruction retires (PC_WE and count still occur) and the next state is HALT. HALTED = 1 in HALT.
- Timeout: the wait counter clears on entry to FETCH/MEM and counts cycles with RDY low. When MEM_TIMEOUT ≠ 0 and the count reaches MEM_TIMEOUT with RDY still low, the next state is TRAP and TIMEOUT is set.
- In HALT and TRAP, all strobes are 0.

## Timing
- Reset (asynchronous):
  - STATE = FETCH; NUM_INST, wait counter and all status flags = 0.
  - All strobe outputs are forced 0 while RSTn = 0.
  - I_MEM_REQ rises combinationally when RSTn deasserts.
- Control outputs are combinational from state, OPCODE, FUNCT3, ADDR_LO, BR_TAKEN and the ready inputs.
- State, counter and flags update on the rising edge of CLK.
- Cycles per instruction with zero wait states: branch 3, ALU/LUI/AUIPC/jump 4, store 4, load 5. Each not-ready cycle adds one.
- A RDY arriving in the same cycle the timeout count is reached wins: no TRAP.
- Reset mid-instruction abandons it with no retire and returns to FETCH.
- NUM_INST is visible incremented the cycle after PC_WE.

## Test plan
- ADDI then BEQ taken, both RDY tied 1:
  - ADDI takes 4 cycles; BEQ takes 3 cycles with PC_SRC = 1 in EXEC.
  - NUM_INST = 2 after 7 cycles.
- LW with D_MEM_RDY low for 3 cycles, MEM_TIMEOUT = 8: MEM held 4 cycles, WB_SEL = 1, instruction total 8 cycles, no TIMEOUT.
- SB with ADDR_LO = 2 gives D_MEM_BE = 0100 and D_MEM_WE = 1. SH with ADDR_LO = 1 gives TRAP, MISALIGN = 1, no D_MEM_WE pulse.
- Opcode 7'h7F gives TRAP after DECODE with ILLEGAL = 1. NUM_INST is unchanged and strobes stay 0 thereafter.
- I_MEM_RDY held low with MEM_TIMEOUT = 5: TRAP with TIMEOUT = 1 after 5 FETCH cycles. Then deassert RSTn mid-TRAP and release: FETCH, flags 0.
- JALR with HALT_REQ = 1 in WB: PC_SRC = 3, WB_SEL = 2, NUM_INST increments, HALT reached, HALTED = 1.
